// File: rtl/tour_pred_unit.sv
// Tournament branch predictor for the 5-stage MIPS pipeline.
// A per-PC local predictor (BHT + local PHT) and a global predictor
// (GHR + global PHT) are arbitrated by a per-PC chooser table (CPHT).
// The prediction is formed in Decode, carried through Execute, checked in
// Memory, and every table is trained from Memory.
// Optional build macro: TOUR_GSHARE_EN selects a gshare global index
// (GHR xor PC bits); when undefined the global index is the GHR alone (GAg).
module tour_pred_unit #(
    parameter int IDX_W  = 6,
    parameter int HIST_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcD,
    input  logic        branchD,
    input  logic        stallD,
    input  logic        flushE,
    input  logic        flushM,
    input  logic [31:0] pcM,
    input  logic        branchM,
    input  logic        actual_takeM,
    output logic        pred_takeD_loc,
    output logic        pred_takeD_glo,
    output logic        pred_takeD,
    output logic        pred_takeM,
    output logic        pred_wrongM
);

    localparam int LOC_N = 1 << IDX_W;
    localparam int PHT_N = 1 << HIST_W;

    // Counter value every PHT/CPHT entry starts from: weakly not-taken,
    // weakly prefer the local component.
    localparam logic [1:0] CTR_INIT = 2'b01;

    // 2-bit saturating counter step: +1 toward 3 when up, -1 toward 0 otherwise.
    function automatic logic [1:0] satStep(input logic [1:0] ctr, input logic up);
        logic [1:0] res;
        if (up) begin
            res = (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end else begin
            res = (ctr == 2'b00) ? ctr : ctr - 2'd1;
        end
        return res;
    endfunction

    // Shift a new outcome into a history register, dropping the oldest bit.
    function automatic logic [HIST_W-1:0] histShift(input logic [HIST_W-1:0] hist,
                                                   input logic taken);
        return {hist[HIST_W-2:0], taken};
    endfunction

    // Prediction tables and global history.
    logic [HIST_W-1:0] bht    [LOC_N];
    logic [1:0]        phtLoc [PHT_N];
    logic [1:0]        phtGlo [PHT_N];
    logic [1:0]        cpht   [LOC_N];
    logic [HIST_W-1:0] ghr;

    // Decode-side lookup signals.
    logic [IDX_W-1:0]  locIdxD;
    logic [HIST_W-1:0] histD;
    logic [HIST_W-1:0] gloIdxD;
    logic              predLocD;
    logic              predGloD;
    logic              chooseGloD;
    logic              predD;

    // Execute-stage copy of the Decode prediction.
    logic              pred_p1;
    logic              predLoc_p1;
    logic              predGlo_p1;
    logic [HIST_W-1:0] locPhtIdx_p1;
    logic [HIST_W-1:0] gloPhtIdx_p1;

    // Memory-stage copy used for checking and training.
    logic              pred_p2;
    logic              predLoc_p2;
    logic              predGlo_p2;
    logic [HIST_W-1:0] locPhtIdx_p2;
    logic [HIST_W-1:0] gloPhtIdx_p2;

    // Memory-side update index and training enables.
    logic [IDX_W-1:0]  locIdxM;
    logic              trainM;
    logic              chooserTrainM;

    // PC bits outside the index fields carry no information for this unit.
    logic unusedPcBits;
    assign unusedPcBits = ^{pcD, pcM};

    // ---------------- Decode: table lookup ----------------
    assign locIdxD = pcD[IDX_W+1:2];
    assign histD   = bht[locIdxD];

`ifdef TOUR_GSHARE_EN
    assign gloIdxD = ghr ^ pcD[HIST_W+1:2];
`else
    assign gloIdxD = ghr;
`endif

    // Component predictions, chooser decision and gated final prediction.
    always_comb begin
        predLocD   = phtLoc[histD][1];
        predGloD   = phtGlo[gloIdxD][1];
        chooseGloD = cpht[locIdxD][1];
        predD      = branchD & (chooseGloD ? predGloD : predLocD);
    end

    assign pred_takeD_loc = predLocD;
    assign pred_takeD_glo = predGloD;
    assign pred_takeD     = predD;

    // ---------------- Decode -> Execute ----------------
    // A stalled Decode instruction is not issued, so Execute gets a bubble
    // exactly as for an explicit flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred_p1      <= 1'b0;
            predLoc_p1   <= 1'b0;
            predGlo_p1   <= 1'b0;
            locPhtIdx_p1 <= '0;
            gloPhtIdx_p1 <= '0;
        end else if (flushE || stallD) begin
            pred_p1      <= 1'b0;
            predLoc_p1   <= 1'b0;
            predGlo_p1   <= 1'b0;
            locPhtIdx_p1 <= '0;
            gloPhtIdx_p1 <= '0;
        end else begin
            pred_p1      <= predD;
            predLoc_p1   <= predLocD;
            predGlo_p1   <= predGloD;
            locPhtIdx_p1 <= histD;
            gloPhtIdx_p1 <= gloIdxD;
        end
    end

    // ---------------- Execute -> Memory ----------------
    // Move the Execute copy into Memory, or insert a bubble on flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred_p2      <= 1'b0;
            predLoc_p2   <= 1'b0;
            predGlo_p2   <= 1'b0;
            locPhtIdx_p2 <= '0;
            gloPhtIdx_p2 <= '0;
        end else if (flushM) begin
            pred_p2      <= 1'b0;
            predLoc_p2   <= 1'b0;
            predGlo_p2   <= 1'b0;
            locPhtIdx_p2 <= '0;
            gloPhtIdx_p2 <= '0;
        end else begin
            pred_p2      <= pred_p1;
            predLoc_p2   <= predLoc_p1;
            predGlo_p2   <= predGlo_p1;
            locPhtIdx_p2 <= locPhtIdx_p1;
            gloPhtIdx_p2 <= gloPhtIdx_p1;
        end
    end

    // ---------------- Memory: check and train ----------------
    // flushM only shapes the next Memory content; the branch currently in
    // Memory still trains on this edge.
    assign locIdxM       = pcM[IDX_W+1:2];
    assign trainM        = branchM;
    assign chooserTrainM = branchM && (predLoc_p2 != predGlo_p2);

    assign pred_takeM = pred_p2;
    // Gated by reset so every output reads 0 while reset is held, even with a
    // resolved branch presented in Memory.
    assign pred_wrongM = rst & branchM & (pred_p2 != actual_takeM);

    // Per-PC local history: shift in the resolved outcome of the Memory branch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LOC_N; i++) begin
                bht[i] <= '0;
            end
        end else if (trainM) begin
            bht[locIdxM] <= histShift(bht[locIdxM], actual_takeM);
        end
    end

    // Global history: shift in every resolved branch outcome.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
        end else if (trainM) begin
            ghr <= histShift(ghr, actual_takeM);
        end
    end

    // Local PHT: train the counter the branch actually read in Decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHT_N; i++) begin
                phtLoc[i] <= CTR_INIT;
            end
        end else if (trainM) begin
            phtLoc[locPhtIdx_p2] <= satStep(phtLoc[locPhtIdx_p2], actual_takeM);
        end
    end

    // Global PHT: the carried index keeps training correct in both index modes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHT_N; i++) begin
                phtGlo[i] <= CTR_INIT;
            end
        end else if (trainM) begin
            phtGlo[gloPhtIdx_p2] <= satStep(phtGlo[gloPhtIdx_p2], actual_takeM);
        end
    end

    // Chooser: when the components disagreed, lean toward whichever was right.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LOC_N; i++) begin
                cpht[i] <= CTR_INIT;
            end
        end else if (chooserTrainM) begin
            cpht[locIdxM] <= satStep(cpht[locIdxM], predGlo_p2 == actual_takeM);
        end
    end

endmodule

// File: tb/tb_tour_pred_unit.sv
// Testbench for tour_pred_unit: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural tournament-predictor model.
module tb_tour_pred_unit;

    localparam int IDX_W  = 6;
    localparam int HIST_W = 6;
    localparam int N      = 1 << IDX_W;
    localparam int H      = 1 << HIST_W;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pcD = '0;
    logic        branchD = 1'b0;
    logic        stallD = 1'b0;
    logic        flushE = 1'b0;
    logic        flushM = 1'b0;
    logic [31:0] pcM = '0;
    logic        branchM = 1'b0;
    logic        actual_takeM = 1'b0;
    logic        pred_takeD_loc;
    logic        pred_takeD_glo;
    logic        pred_takeD;
    logic        pred_takeM;
    logic        pred_wrongM;

    tour_pred_unit #(.IDX_W(IDX_W), .HIST_W(HIST_W)) dut (
        .clk(clk), .rst(rst), .pcD(pcD), .branchD(branchD), .stallD(stallD),
        .flushE(flushE), .flushM(flushM), .pcM(pcM), .branchM(branchM),
        .actual_takeM(actual_takeM), .pred_takeD_loc(pred_takeD_loc),
        .pred_takeD_glo(pred_takeD_glo), .pred_takeD(pred_takeD),
        .pred_takeM(pred_takeM), .pred_wrongM(pred_wrongM)
    );

    always #5 clk = ~clk;

    // One in-flight instruction as the model sees it.
    typedef struct packed {
        bit br;
        bit take;
        int pc;
        bit pred;
        bit loc;
        bit glo;
        int lidx;
        int gi;
    } slot_t;

    int    mBht[N];
    int    mPhtL[H];
    int    mPhtG[H];
    int    mCh[N];
    int    mGhr;
    slot_t sE;
    slot_t sM;

    int checks = 0;
    int errors = 0;
    bit obsPredD, obsPredM, obsWrong;

    function automatic int sat(input int v);
        return (v < 0) ? 0 : ((v > 3) ? 3 : v);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mBht[i] = 0;
            mCh[i]  = 1;
        end
        for (int i = 0; i < H; i++) begin
            mPhtL[i] = 1;
            mPhtG[i] = 1;
        end
        mGhr = 0;
        sE   = '0;
        sM   = '0;
    endtask

    task automatic doReset();
        rst = 1'b0;
        pcD = '0; branchD = 0; stallD = 0; flushE = 0; flushM = 0;
        pcM = '0; branchM = 0; actual_takeM = 0;
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock: drive at negedge, compare all outputs, then advance the model.
    task automatic cycle(input int pc, input bit br, input bit tk,
                         input bit st, input bit fe, input bit fm);
        slot_t d;
        int    li;
        int    mi;
        bit    sel;
        d = '0;
        pcD = pc; branchD = br; stallD = st; flushE = fe; flushM = fm;
        pcM = sM.pc; branchM = sM.br; actual_takeM = sM.take;
        #1;
        li     = (pc >> 2) % N;
        d.lidx = mBht[li];
        d.loc  = (mPhtL[d.lidx] >= 2);
`ifdef TOUR_GSHARE_EN
        d.gi   = mGhr ^ ((pc >> 2) % H);
`else
        d.gi   = mGhr;
`endif
        d.glo  = (mPhtG[d.gi] >= 2);
        sel    = (mCh[li] >= 2) ? d.glo : d.loc;
        d.pred = br & sel;
        d.br   = br;
        d.take = tk;
        d.pc   = pc;

        checks += 5;
        if (pred_takeD !== d.pred) begin
            errors++;
            $display("FAIL predD pc=%0h: got %0b expected %0b", pc, pred_takeD, d.pred);
        end
        if (pred_takeD_loc !== d.loc) begin
            errors++;
            $display("FAIL locD pc=%0h: got %0b expected %0b", pc, pred_takeD_loc, d.loc);
        end
        if (pred_takeD_glo !== d.glo) begin
            errors++;
            $display("FAIL gloD pc=%0h: got %0b expected %0b", pc, pred_takeD_glo, d.glo);
        end
        if (pred_takeM !== sM.pred) begin
            errors++;
            $display("FAIL predM: got %0b expected %0b", pred_takeM, sM.pred);
        end
        if (pred_wrongM !== (sM.br & (sM.pred != sM.take))) begin
            errors++;
            $display("FAIL wrongM: got %0b expected %0b", pred_wrongM,
                     sM.br & (sM.pred != sM.take));
        end
        obsPredD = pred_takeD;
        obsPredM = pred_takeM;
        obsWrong = pred_wrongM;

        @(posedge clk);
        if (sM.br) begin
            mi = (sM.pc >> 2) % N;
            mPhtL[sM.lidx] = sat(mPhtL[sM.lidx] + (sM.take ? 1 : -1));
            mPhtG[sM.gi]   = sat(mPhtG[sM.gi] + (sM.take ? 1 : -1));
            if (sM.loc != sM.glo)
                mCh[mi] = sat(mCh[mi] + ((sM.glo == sM.take) ? 1 : -1));
            mBht[mi] = ((mBht[mi] << 1) | int'(sM.take)) % H;
            mGhr     = ((mGhr << 1) | int'(sM.take)) % H;
        end
        sM = fm ? slot_t'('0) : sE;
        sE = (fe || st) ? slot_t'('0) : d;
        @(negedge clk);
    endtask

    // Issue one branch and let it reach Memory before anything else is fetched.
    bit issPred;
    task automatic issue(input int pc, input bit tk);
        cycle(pc, 1, tk, 0, 0, 0);
        issPred = obsPredD;
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        pcD = 32'h10; branchD = 1; branchM = 1; actual_takeM = 1;
        #1;
        checks++;
        if ({pred_takeD, pred_takeD_loc, pred_takeD_glo, pred_takeM, pred_wrongM} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {pred_takeD, pred_takeD_loc, pred_takeD_glo, pred_takeM, pred_wrongM});
        end
        doReset();
        cycle(32'h10, 1, 0, 0, 0, 0);
        checks++;
        if (obsPredD !== 1'b0) begin
            errors++;
            $display("FAIL first_pred: got %0b expected 0", obsPredD);
        end
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        checks++;
        if (obsPredM !== 1'b0) begin
            errors++;
            $display("FAIL first_predM: got %0b expected 0", obsPredM);
        end
    endtask

    task automatic test_taken_twice();
        doReset();
        issue(32'h10, 1);
        issue(32'h10, 1);
        checks++;
        if (obsWrong !== 1'b1) begin
            errors++;
            $display("FAIL second_wrong: got %0b expected 1", obsWrong);
        end
        issue(32'h10, 1);
        checks++;
        if (issPred !== 1'b0) begin
            errors++;
            $display("FAIL third_pred: got %0b expected 0", issPred);
        end
    endtask

    task automatic test_loop();
        int wrongs;
        wrongs = 0;
        doReset();
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < 4; k++) begin
                issue(32'h20, (k != 3));
                if (it >= 6 && obsWrong) wrongs++;
            end
        end
        checks++;
        if (wrongs !== 0) begin
            errors++;
            $display("FAIL loop_last2_wrongs: got %0d expected 0", wrongs);
        end
    endtask

    task automatic test_correlated();
        int wrongs;
        bit o;
        wrongs = 0;
        doReset();
        for (int it = 0; it < 16; it++) begin
            o = (it % 2) == 0;
            issue(32'h84, o);
            if (it >= 12 && obsWrong) wrongs++;
            issue(32'hC8, o);
            if (it >= 12 && obsWrong) wrongs++;
        end
        checks++;
        if (wrongs !== 0) begin
            errors++;
            $display("FAIL correlated_wrongs: got %0d expected 0", wrongs);
        end
    endtask

    task automatic test_stall_flush();
        doReset();
        repeat (10) issue(32'h40, 1);
        checks++;
        if (issPred !== 1'b1) begin
            errors++;
            $display("FAIL trained_pred: got %0b expected 1", issPred);
        end
        cycle(32'h40, 1, 1, 1, 0, 0);
        cycle(32'h40, 1, 1, 1, 0, 0);
        cycle(32'h40, 1, 1, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0, 0, 0);
            checks++;
            if (obsPredM !== 1'b0 || obsWrong !== 1'b0) begin
                errors++;
                $display("FAIL stall_bubble_M%0d: got predM=%0b wrong=%0b expected 0 0",
                         k, obsPredM, obsWrong);
            end
        end
        cycle(32'h40, 1, 1, 0, 0, 0);
        checks++;
        if (obsPredD !== 1'b1) begin
            errors++;
            $display("FAIL pred_after_stall: got %0b expected 1", obsPredD);
        end
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_mid_reset();
        doReset();
        repeat (10) issue(32'h40, 1);
        pcD = 32'h40; branchD = 1; stallD = 0; flushE = 0; flushM = 0;
        pcM = 32'h40; branchM = 1; actual_takeM = 1;
        #1;
        checks++;
        if (pred_takeD !== 1'b1 || pred_wrongM !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got predD=%0b wrong=%0b expected 1 1",
                     pred_takeD, pred_wrongM);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({pred_takeD, pred_takeD_loc, pred_takeD_glo, pred_takeM, pred_wrongM} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %b expected 00000",
                     {pred_takeD, pred_takeD_loc, pred_takeD_glo, pred_takeM, pred_wrongM});
        end
        @(posedge clk);
        @(negedge clk);
        modelReset();
        branchM = 0; actual_takeM = 0;
        rst = 1'b1;
        cycle(32'h40, 1, 1, 0, 0, 0);
        checks++;
        if (obsPredD !== 1'b0) begin
            errors++;
            $display("FAIL pred_after_reset: got %0b expected 0", obsPredD);
        end
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random_back_to_back();
        int pc;
        bit br, tk, st, fe, fm;
        doReset();
        for (int n = 0; n < 600; n++) begin
            pc = 32'h100 + 4 * int'($urandom_range(0, 7));
            br = ($urandom_range(0, 3) != 0);
            // Mostly pc-dependent outcomes so the predictors have something to learn.
            tk = ($urandom_range(0, 7) == 0) ? bit'($urandom_range(0, 1))
                                              : bit'(((pc >> 2) + n / 16) % 2);
            st = ($urandom_range(0, 9) == 0);
            fe = ($urandom_range(0, 11) == 0);
            fm = ($urandom_range(0, 11) == 0);
            cycle(pc, br, tk, st, fe, fm);
        end
    endtask

    initial begin
        test_reset();
        test_taken_twice();
        test_loop();
        test_correlated();
        test_stall_flush();
        test_mid_reset();
        test_random_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
